// File: rtl/core_pkg.sv
// Shared constants and types for the integer core control path.
package core_pkg;

  localparam logic [6:0]  OPC_RTYPE   = 7'b0110011;
  localparam logic [6:0]  OPC_ITYPE   = 7'b0010011;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXECUTE    = 3'd3,
    ST_WRITEBACK  = 3'd4,
    ST_TRAP       = 3'd5
  } seq_state_e;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE);
  endfunction

endpackage

// File: rtl/core_sequencer_pc_reg.sv
// Program counter: loads RESET_PC on reset, advances one instruction on inc.
module pc_reg
  import core_pkg::*;
#(
  parameter int unsigned           WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [WORD_SIZE-1:0] pc
);

  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc) begin
      pc_d = pc_q + WORD_SIZE'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning the IR and PC.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned           WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [WORD_SIZE-1:0] imem_rsp_data,
  output logic [WORD_SIZE-1:0] instr,
  input  logic [6:0]           opcode,
  input  logic                 stall,
  output logic                 alu_en,
  output logic                 rf_we,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 retire,
  output logic                 trap
);

  seq_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;

  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    imem_req_valid = 1'b0;
    alu_en         = 1'b0;
    rf_we          = 1'b0;
    retire         = 1'b0;
    trap           = 1'b0;
    unique case (state_q)
      ST_FETCH_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = ST_FETCH_WAIT;
      end
      // Responses are only captured here, so a same-cycle or aborted-fetch response is dropped.
      ST_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = is_legal_opcode(opcode) ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        alu_en = 1'b1;
        if (!stall) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH_REQ;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = ST_FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH_REQ;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  pc_reg #(
    .WORD_SIZE (WORD_SIZE),
    .RESET_PC  (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == ST_WRITEBACK),
    .pc    (pc)
  );

  assign imem_req_addr = pc;
  assign instr         = ir_q;

endmodule
